instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle sequencer for the 3-bit-opcode processor datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and emits the per-cycle enables that qualify the static control decoder outputs (PC advance, IR load, register write, memory request). It also handles the data-memory ready handshake with a timeout, halts on a halt opcode, and counts retired instructions.

Parameters:
OPW, 3, opcode width
CNTW, 16, retired-instruction counter width
MEM_TIMEOUT, 15, max cycles in MEM without MemReady before error abort (min 1)
HALT_OP, 3'b110, opcode that halts the sequencer

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  begin or resume execution; sampled only in IDLE/DONE
Opcode  in  OPW  opcode from the instruction register; valid from DECODE onward
BranchTaken  in  1  ALU branch condition; sampled in EXEC only
MemReady  in  1  data memory completion; sampled in MEM only
IRLoad  out  1  load instruction register
PCEn  out  1  advance PC this cycle
BranchEn  out  1  PC loads branch target instead of PC+1 (only with PCEn)
RegWriteEn  out  1  qualifies register-file write
MemReq  out  1  data memory request, held through MEM
MemWe  out  1  store strobe, only with MemReq
Busy  out  1  high in FETCH..WB
Done  out  1  high in DONE
Error  out  1  sticky memory-timeout flag
InstrCount  out  CNTW  retired instructions, saturating

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE. State register reset to IDLE. Wait counter, InstrCount and Error reset to 0.
- Outputs decode combinationally from state, plus BranchTaken in EXEC and Opcode. After a reset edge, every output is 0.
- IDLE: Start=1 -> FETCH and clear InstrCount/Error. Otherwise stay.
- FETCH: IRLoad=1 -> DECODE.
- DECODE: Opcode==HALT_OP -> DONE (not counted). Otherwise -> EXEC.
- EXEC: opcode 000 (load) or 001 (store) -> MEM, with wait counter cleared.
- EXEC: opcode 010 (branch) asserts PCEn=1 and BranchEn=BranchTaken -> FETCH.
- EXEC: all other opcodes -> WB.
- MEM: MemReq=1 every cycle; MemWe=1 iff store.
- MEM, MemReady=1: load -> WB; store asserts PCEn=1 -> FETCH.
- MEM, MemReady=0: wait counter increments. When the counter reaches MEM_TIMEOUT -> DONE with Error=1, no PCEn.
- MEM: if MemReady=1 on the timeout cycle, ready wins.
- WB: RegWriteEn=1, PCEn=1 -> FETCH.
- InstrCount increments by 1 on every cycle with PCEn=1 and saturates at all-ones.
- DONE: Done=1; Error holds. Start=1 -> FETCH, clears Error, keeps InstrCount; PC is not touched.
- Latency (FETCH to next FETCH): ALU/rotate/and = 4 cycles; branch = 3; store = 4 + wait cycles; load = 5 + wait cycles.
- Start outside IDLE/DONE is ignored. MemReady outside MEM is ignored. BranchTaken outside EXEC is ignored.
- Reset mid-operation, including mid-MEM: IDLE next edge, MemReq drops that edge, no partial write-back.
- Unused state encodings -> IDLE.
- Invariants: exactly one PCEn per retired instruction; never MemWe without MemReq; never BranchEn without PCEn.

Test Plan:
- Reset, then Start pulse, Opcode=3'b100 -> IRLoad@1, PCEn+RegWriteEn@4, IRLoad again @5; after 3 instrs InstrCount=3.
- Branch 010, BranchTaken=1 then 0 -> EXEC cycle shows PCEn=1/BranchEn=1, then PCEn=1/BranchEn=0; no RegWriteEn; 3-cycle period.
- Load 000 with MemReady after 3 wait cycles -> MemReq high 4 cycles, MemWe=0, then WB RegWriteEn=1; store 001 with MemReady=1 immediately -> MemReq=MemWe=1 one cycle, PCEn same cycle.
- Store with MemReady stuck 0 and MEM_TIMEOUT=15 -> DONE after 15 wait cycles, Error=1, InstrCount unchanged; variant with MemReady on cycle 15 -> normal retire, Error=0.
- Opcode=HALT_OP after 2 instrs -> Done=1, Busy=0, InstrCount=2; Start -> FETCH, Done=0, InstrCount stays 2. Start asserted while Busy -> no effect.
- Reset asserted during MEM wait -> next cycle IDLE, all outputs 0, InstrCount=0; CNTW=4 run of 17 ALU instrs -> InstrCount saturates at 15.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Handshake/control bundle between the instruction sequencer and its datapath.
// The master side drives start/opcode/status; the slave (sequencer) drives enables.
`timescale 1ns/1ps
interface instr_sequencer_if #(
  parameter int OPW  = 3,
  parameter int CNTW = 16
);
  logic            start;
  logic [OPW-1:0]  opcode;
  logic            branch_taken;
  logic            mem_ready;
  logic            ir_load;
  logic            pc_en;
  logic            branch_en;
  logic            reg_write_en;
  logic            mem_req;
  logic            mem_we;
  logic            busy;
  logic            done;
  logic            error;
  logic [CNTW-1:0] instr_count;

  modport master (
    output start, opcode, branch_taken, mem_ready,
    input  ir_load, pc_en, branch_en, reg_write_en, mem_req, mem_we,
           busy, done, error, instr_count
  );

  modport slave (
    input  start, opcode, branch_taken, mem_ready,
    output ir_load, pc_en, branch_en, reg_write_en, mem_req, mem_we,
           busy, done, error, instr_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready timeout,
// halt detection and a saturating retired-instruction counter.
`timescale 1ns/1ps
module instr_sequencer #(
  parameter int             OPW         = 3,
  parameter int             CNTW        = 16,
  parameter int             MEM_TIMEOUT = 15,
  parameter logic [OPW-1:0] HALT_OP     = OPW'(6)
) (
  input logic               clk_i,
  input logic               reset_i,
  instr_sequencer_if.slave  bus
);

  localparam int             WW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0]  WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  localparam logic [OPW-1:0] OP_LOAD   = OPW'(0);
  localparam logic [OPW-1:0] OP_STORE  = OPW'(1);
  localparam logic [OPW-1:0] OP_BRANCH = OPW'(2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic ir_load, pc_en, branch_en, reg_write_en, mem_req, mem_we, busy, done;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    wait_d       = wait_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    branch_en    = 1'b0;
    reg_write_en = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        ir_load = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        busy    = 1'b1;
        state_d = (bus.opcode == HALT_OP) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (bus.opcode == OP_BRANCH) begin
          pc_en     = 1'b1;
          branch_en = bus.branch_taken;
          state_d   = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = (bus.opcode == OP_STORE);
        // Ready on the final allowed cycle still completes the access.
        if (bus.mem_ready) begin
          if (bus.opcode == OP_STORE) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB: begin
        busy         = 1'b1;
        reg_write_en = 1'b1;
        pc_en        = 1'b1;
        state_d      = S_FETCH;
      end
      S_DONE: begin
        done = 1'b1;
        if (bus.start) begin
          state_d = S_FETCH;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pc_en && (cnt_q != '1)) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_i) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.ir_load      = ir_load;
  assign bus.pc_en        = pc_en;
  assign bus.branch_en    = branch_en;
  assign bus.reg_write_en = reg_write_en;
  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.error        = err_q;
  assign bus.instr_count  = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Cycle-accurate bench for instr_sequencer: per-cycle expected enables are queued
// as stimulus is applied and compared against the DUT at the falling edge.
`timescale 1ns/1ps
module tb_instr_sequencer;

  localparam logic [8:0] F_NONE = 9'b000000000;
  localparam logic [8:0] F_IR   = 9'b100000000;
  localparam logic [8:0] F_PC   = 9'b010000000;
  localparam logic [8:0] F_BR   = 9'b001000000;
  localparam logic [8:0] F_RW   = 9'b000100000;
  localparam logic [8:0] F_MR   = 9'b000010000;
  localparam logic [8:0] F_MW   = 9'b000001000;
  localparam logic [8:0] F_B    = 9'b000000100;
  localparam logic [8:0] F_DN   = 9'b000000010;
  localparam logic [8:0] F_ER   = 9'b000000001;

  typedef struct {
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        bt;
    logic        mr;
    logic [8:0]  flags;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [8:0]  flags;
    logic [15:0] cnt;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   step_no = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  instr_sequencer_if #(.OPW(3), .CNTW(16)) bus ();
  instr_sequencer_if #(.OPW(3), .CNTW(4))  sbus ();

  instr_sequencer dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  instr_sequencer #(.CNTW(4)) sdut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (sbus)
  );

  function automatic logic [8:0] flags_now();
    return {bus.ir_load, bus.pc_en, bus.branch_en, bus.reg_write_en, bus.mem_req,
            bus.mem_we, bus.busy, bus.done, bus.error};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, compare at the falling edge.
  task automatic step(input logic rst, input logic st, input logic [2:0] op, input logic bt,
                      input logic mr, input logic [8:0] fl, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk); #1;
    reset            = rst;
    bus.start        = st;
    bus.opcode       = op;
    bus.branch_taken = bt;
    bus.mem_ready    = mr;
    e.flags = fl;
    e.cnt   = cnt;
    e.idx   = step_no;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("step%0d_flags", e.idx), 32'(flags_now()), 32'(e.flags));
    check($sformatf("step%0d_count", e.idx), 32'(bus.instr_count), 32'(e.cnt));
    step_no++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b0;
    sbus.start       = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_flags", 32'(flags_now()), 32'(F_NONE));
    check("reset_count", 32'(bus.instr_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;  bus.opcode = 3'b000;  bus.branch_taken = 1'b0;  bus.mem_ready = 1'b0;
    sbus.start = 1'b0; sbus.opcode = 3'b100; sbus.branch_taken = 1'b0; sbus.mem_ready = 1'b0;

    // ALU x3 (start while busy ignored), branch taken/not taken, load with 3 waits,
    // immediate store, halt, resume from DONE keeping the count.
    vecs.push_back('{1'b0, 1'b1, 3'b100, 1'b0, 1'b0, F_NONE,           16'd0});
    vecs.push_back('{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, F_IR | F_B,       16'd0});
    vecs.push_back('{1'b0, 1'b1, 3'b100, 1'b0, 1'b0, F_B,              16'd0});
    vecs.push_back('{1'b0, 1'b0, 3'b100, 1'b1, 1'b1, F_B,              16'd0});
    vecs.push_back('{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, F_PC | F_RW | F_B, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 3'b101, 1'b0, 1'b0, F_IR | F_B,       16'd1});
    vecs.push_back('{1'b0, 1'b0, 3'b101, 1'b0, 1'b0, F_B,              16'd1});
    vecs.push_back('{1'b0, 1'b0, 3'b101, 1'b0, 1'b0, F_B,              16'd1});
    vecs.push_back('{1'b0, 1'b0, 3'b101, 1'b0, 1'b0, F_PC | F_RW | F_B, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 3'b111, 1'b0, 1'b0, F_IR | F_B,       16'd2});
    vecs.push_back('{1'b0, 1'b0, 3'b111, 1'b0, 1'b0, F_B,              16'd2});
    vecs.push_back('{1'b0, 1'b0, 3'b111, 1'b0, 1'b0, F_B,              16'd2});
    vecs.push_back('{1'b0, 1'b0, 3'b111, 1'b0, 1'b0, F_PC | F_RW | F_B, 16'd2});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 1'b0, 1'b0, F_IR | F_B,       16'd3});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 1'b0, 1'b0, F_B,              16'd3});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 1'b1, 1'b0, F_PC | F_BR | F_B, 16'd3});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 1'b1, 1'b0, F_IR | F_B,       16'd4});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 1'b1, 1'b0, F_B,              16'd4});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 1'b0, 1'b0, F_PC | F_B,       16'd4});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_IR | F_B,       16'd5});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_B,              16'd5});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, F_B,              16'd5});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_MR | F_B,       16'd5});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_MR | F_B,       16'd5});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_MR | F_B,       16'd5});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, F_MR | F_B,       16'd5});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_PC | F_RW | F_B, 16'd5});
    vecs.push_back('{1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_IR | F_B,       16'd6});
    vecs.push_back('{1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_B,              16'd6});
    vecs.push_back('{1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_B,              16'd6});
    vecs.push_back('{1'b0, 1'b0, 3'b001, 1'b0, 1'b1, F_PC | F_MR | F_MW | F_B, 16'd6});
    vecs.push_back('{1'b0, 1'b0, 3'b110, 1'b0, 1'b0, F_IR | F_B,       16'd7});
    vecs.push_back('{1'b0, 1'b0, 3'b110, 1'b0, 1'b0, F_B,              16'd7});
    vecs.push_back('{1'b0, 1'b0, 3'b110, 1'b0, 1'b0, F_DN,             16'd7});
    vecs.push_back('{1'b0, 1'b1, 3'b110, 1'b0, 1'b0, F_DN,             16'd7});
    vecs.push_back('{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, F_IR | F_B,       16'd7});

    do_reset();
    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].start, vecs[i].op, vecs[i].bt, vecs[i].mr,
           vecs[i].flags, vecs[i].cnt);

    // Store timeout: 15 wait cycles -> DONE with sticky error, count unchanged;
    // then resume and retire a store whose ready arrives on the 15th cycle.
    do_reset();
    step(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, F_NONE, 16'd0);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_IR | F_B, 16'd0);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_B, 16'd0);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_B, 16'd0);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, F_PC | F_MR | F_MW | F_B, 16'd0);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_IR | F_B, 16'd1);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_B, 16'd1);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_B, 16'd1);
    for (int i = 0; i < 15; i++)
      step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_MR | F_MW | F_B, 16'd1);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, F_DN | F_ER, 16'd1);
    step(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, F_DN | F_ER, 16'd1);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_IR | F_B, 16'd1);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_B, 16'd1);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_B, 16'd1);
    for (int i = 0; i < 14; i++)
      step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_MR | F_MW | F_B, 16'd1);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, F_PC | F_MR | F_MW | F_B, 16'd1);
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, F_IR | F_B, 16'd2);

    // Reset during a load's MEM wait (ready arriving with reset): no write-back.
    do_reset();
    step(1'b0, 1'b1, 3'b100, 1'b0, 1'b0, F_NONE, 16'd0);
    step(1'b0, 1'b0, 3'b100, 1'b0, 1'b0, F_IR | F_B, 16'd0);
    step(1'b0, 1'b0, 3'b100, 1'b0, 1'b0, F_B, 16'd0);
    step(1'b0, 1'b0, 3'b100, 1'b0, 1'b0, F_B, 16'd0);
    step(1'b0, 1'b0, 3'b100, 1'b0, 1'b0, F_PC | F_RW | F_B, 16'd0);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_IR | F_B, 16'd1);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_B, 16'd1);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_B, 16'd1);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_MR | F_B, 16'd1);
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, F_MR | F_B, 16'd1);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, F_NONE, 16'd0);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, F_NONE, 16'd0);

    // 4-bit counter: 17 ALU instructions saturate at 15.
    do_reset();
    @(posedge clk); #1;
    sbus.start = 1'b1;
    @(posedge clk); #1;
    sbus.start = 1'b0;
    repeat (56) @(posedge clk);
    @(negedge clk);
    check("sat_count_14", 32'(sbus.instr_count), 32'd14);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sat_count_15", 32'(sbus.instr_count), 32'd15);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("sat_count_hold", 32'(sbus.instr_count), 32'd15);
    check("sat_busy", 32'(sbus.busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
